// File: rtl/program_counter_if.sv
// Bus bundle for the program counter: branch-load request in, current pc (and optional wrap flag) out.
// Macro PC_WRAP_FLAG_EN adds the wrap signal.
interface program_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] new_addr;
    logic [WIDTH-1:0] pc;
`ifdef PC_WRAP_FLAG_EN
    logic             wrap;
`endif

`ifdef PC_WRAP_FLAG_EN
    modport master (output load, output new_addr, input pc, input wrap);
    modport slave  (input load, input new_addr, output pc, output wrap);
`else
    modport master (output load, output new_addr, input pc);
    modport slave  (input load, input new_addr, output pc);
`endif
endinterface

// File: rtl/program_counter.sv
// Program counter: synchronous reset > load > increment, wrapping modulo 2^WIDTH.
// Macro PC_WRAP_FLAG_EN adds a registered one-cycle wrap flag on the increment from all-ones to zero.
module program_counter #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    program_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] PC_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] PC_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_at_top;

    assign w_pc_inc = r_pc + PC_ONE;
    assign w_at_top = (r_pc == PC_ALL_ONES);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VECTOR;
        end else if (bus.load) begin
            r_pc <= bus.new_addr;
        end else begin
            r_pc <= w_pc_inc;
        end
    end

    assign bus.pc = r_pc;

`ifdef PC_WRAP_FLAG_EN
    logic r_wrap;

    // Flag only the increment edge that leaves all-ones; loads and reset clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_at_top;
        end
    end

    assign bus.wrap = r_wrap;
`else
    logic w_unused;
    assign w_unused = w_at_top;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed sequences then random reset/load/free-run traffic.
module tb_program_counter;
    localparam int unsigned WIDTH = 8;
    localparam int          MOD   = 256;

    logic clk;
    logic reset;

    program_counter_if #(.WIDTH(WIDTH)) bus ();

    program_counter #(.WIDTH(WIDTH), .RESET_VECTOR(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int exp_pc;
    int exp_wrap;

    task automatic check(input string tag);
        total++;
        assert (bus.pc === WIDTH'(exp_pc)) else begin
            bad++;
            $error("FAIL %s pc=%0h expected=%0h", tag, bus.pc, WIDTH'(exp_pc));
        end
`ifdef PC_WRAP_FLAG_EN
        total++;
        assert (bus.wrap === 1'(exp_wrap)) else begin
            bad++;
            $error("FAIL %s_wrap wrap=%0b expected=%0b", tag, bus.wrap, 1'(exp_wrap));
        end
`endif
    endtask

    // One clock edge: drive inputs at the falling edge, update the model, sample after the rising edge.
    task automatic step(input logic r, input logic l, input int a, input string tag);
        int prev;
        @(negedge clk);
        reset        = r;
        bus.load     = l;
        bus.new_addr = WIDTH'(a);
        @(posedge clk);
        prev = exp_pc;
        if (r) begin
            exp_pc   = 0;
            exp_wrap = 0;
        end else if (l) begin
            exp_pc   = a % MOD;
            exp_wrap = 0;
        end else begin
            exp_pc   = (prev + 1) % MOD;
            exp_wrap = (prev == MOD - 1) ? 1 : 0;
        end
        #1;
        check(tag);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        exp_pc       = 0;
        exp_wrap     = 0;
        reset        = 1'b0;
        bus.load     = 1'b0;
        bus.new_addr = '0;

        // Reset then free count
        step(1'b1, 1'b0, 0, "reset");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, "count_after_reset");

        // Single load then count
        step(1'b0, 1'b1, 8'h10, "load_10");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, "count_after_load");

        // Wrap through all-ones
        step(1'b0, 1'b1, 8'hFE, "load_fe");
        step(1'b0, 1'b0, 0, "pc_ff");
        step(1'b0, 1'b0, 0, "pc_00_wrap");
        step(1'b0, 1'b0, 0, "pc_01");

        // Reset beats load on the same edge
        step(1'b1, 1'b1, 8'h55, "reset_over_load");
        step(1'b0, 1'b1, 8'h55, "load_55");

        // Held load tracks new_addr
        step(1'b0, 1'b1, 8'h20, "held_20a");
        step(1'b0, 1'b1, 8'h20, "held_20b");
        step(1'b0, 1'b1, 8'h30, "held_30");
        step(1'b0, 1'b0, 0, "after_held_31");

        // Load of zero from all-ones must not raise wrap
        step(1'b0, 1'b1, 8'hFF, "load_ff");
        step(1'b0, 1'b1, 8'h00, "load_zero");

        // Load pulse between edges is ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset        = 1'b0;
            bus.load     = 1'b0;
            bus.new_addr = 8'hAA;
            #1 bus.load  = 1'b1;
            #2 bus.load  = 1'b0;
            @(posedge clk);
            exp_wrap = (exp_pc == MOD - 1) ? 1 : 0;
            exp_pc   = (exp_pc + 1) % MOD;
            #1;
            check("glitch_ignored");
        end

        // Randomized traffic, biased toward the wrap boundary
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic l;
            int   a;
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 255));
            step(r, l, a, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter WIDTH, default 8, sets the address/PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0 (WIDTH bits), sets the value loaded into pc on reset.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  when high, pc takes new_addr at the next rising edge.
REQ-006 new_addr  input  WIDTH  jump/branch target address.
REQ-007 pc  output  WIDTH  current program counter, registered.
REQ-008 The block SHALL use one clock (clk); reset SHALL be synchronous and active-high.

Function
REQ-009 On each rising clk edge, pc SHALL update by priority: reset, then load, then increment.
REQ-010 With reset high at the edge, pc SHALL become RESET_VECTOR regardless of load or new_addr.
REQ-011 With reset low and load high at the edge, pc SHALL become new_addr.
REQ-012 With reset and load low at the edge, pc SHALL become pc+1 modulo 2^WIDTH.
REQ-013 Increment SHALL wrap from all-ones to zero (0xFF -> 0x00 at WIDTH=8) with no stall or error.
REQ-014 Load latency SHALL be one edge: the loaded value appears on pc after the edge where load is sampled high, and increments resume on the following edge.
REQ-015 Load held high for N edges SHALL reload new_addr on each of those edges, holding pc at new_addr (tracking any new_addr changes).
REQ-016 load and new_addr SHALL be sampled only at rising edges; changes between edges SHALL have no effect on pc.
REQ-017 pc SHALL be driven directly from a register, with no combinational path from any input to pc.

Reset
REQ-018 pc SHALL be RESET_VECTOR (0x00 by default) after any edge with reset high.
REQ-019 Reset asserted mid-count or together with load SHALL override both.
REQ-020 Before the first reset edge, pc SHALL be treated as undefined; benches SHALL apply reset before checking pc.
REQ-021 After reset deasserts, the first increment SHALL occur on the first edge with reset low (RESET_VECTOR -> RESET_VECTOR+1).

Configuration
REQ-022 Macro PC_WRAP_FLAG_EN, when defined, SHALL add output wrap (1 bit, registered), high for exactly the one cycle after an increment edge that takes pc from all-ones to zero.
REQ-023 wrap SHALL be 0 after reset and after any load edge, including a load of zero.
REQ-024 Without PC_WRAP_FLAG_EN, the wrap port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 Reset: reset=1 for one edge, then 0 for five edges -> pc sequence 0x00, 0x01, 0x02, 0x03, 0x04, 0x05.
REQ-026 Load: load=1 with new_addr=0x10 for one edge, then load=0 for five edges -> pc 0x10, 0x11, 0x12, 0x13, 0x14, 0x15.
REQ-027 Wrap: load 0xFE, then free-run -> pc 0xFE, 0xFF, 0x00, 0x01; with PC_WRAP_FLAG_EN, wrap=1 only in the 0x00 cycle.
REQ-028 Priority: reset=1 and load=1 with new_addr=0x55 on the same edge -> pc=0x00; load alone on the next edge -> pc=0x55.
REQ-029 Held load: load=1 for three edges with new_addr 0x20, 0x20, 0x30 -> pc 0x20, 0x20, 0x30; load=0 -> 0x31.
REQ-030 Mid-edge glitch: pulse load between two edges without covering an edge -> pc keeps incrementing unchanged.
